// File: rtl/pipeline_result_pkg.sv
// Shared types and constants for the pipeline result FIFO.
package pipeline_result_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    OVF_HOLD = 1'b1
  } state_t;

  localparam int DROP_CNT_WIDTH = 16;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pipeline_result_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
module pipeline_result_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_result_fifo.sv
// First-word-fall-through capture FIFO for the pipeline host's result port.
// Optional running XOR checksum of accepted words: PIPELINE_RESULT_FIFO_CHECKSUM_EN.
module pipeline_result_fifo
  import pipeline_result_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [ADDR_WIDTH:0]       level,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count
`ifdef PIPELINE_RESULT_FIFO_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]     checksum
`endif
);

  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH+1)'(DEPTH);

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     rd_ptr;
  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic [ADDR_WIDTH:0]       level_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  logic                      overflow_q;

  logic pop;
  logic push;
  logic drop;
  logic mem_we;

  assign level         = level_q;
  assign full          = (level_q == LEVEL_FULL);
  assign empty         = (level_q == '0);
  assign out_valid     = !empty;
  assign overflow      = overflow_q;
  assign dropped_count = drop_cnt;

  assign pop    = out_valid && out_ready;
  assign push   = in_valid && (state == RUN) && (!full || pop);
  assign drop   = in_valid && !push;
  // Flush discards the same-cycle push, so the array must not be written either.
  assign mem_we = push && !flush && !rst;

  pipeline_result_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Once a word is lost, stay in OVF_HOLD until software flushes or resets.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= RUN;
      overflow_q <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt != DROP_CNT_MAX) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
      case (state)
        RUN: begin
          if (drop) begin
            state <= OVF_HOLD;
          end
        end
        OVF_HOLD: begin
          state <= OVF_HOLD;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef PIPELINE_RESULT_FIFO_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  assign checksum = checksum_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      checksum_q <= '0;
    end else if (push) begin
      checksum_q <= checksum_q ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_result_fifo.sv
// Scoreboard testbench for pipeline_result_fifo with a queue-based reference model.
// Also checks the checksum output when PIPELINE_RESULT_FIFO_CHECKSUM_EN is defined.
module tb_pipeline_result_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [15:0]   dropped_count;
`ifdef PIPELINE_RESULT_FIFO_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state: occupancy, hold flag, drop tally, checksum; sb_q holds expected output order.
  logic [DW-1:0] sb_q [$];
  int            m_cnt;
  bit            m_hold;
  int            m_drops;
  logic [DW-1:0] m_xor;

  pipeline_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .flush         (flush),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .dropped_count (dropped_count)
`ifdef PIPELINE_RESULT_FIFO_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit rdy, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Monitor: every accepted head word must be the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_pop", out_data, 'x);
      end else begin
        checkOutput("out_data", out_data, sb_q.pop_front());
      end
    end
  end

  // Model: compare status against reference, then predict the next edge.
  always @(negedge clk) begin
    bit m_pop;
    bit m_push;
    #1;
    if (rst === 1'b1) begin
      m_cnt = 0; m_hold = 0; m_drops = 0; m_xor = '0;
      sb_q.delete();
    end else begin
      checkOutput("level", DW'(level), DW'(m_cnt));
      checkOutput("out_valid", DW'(out_valid), DW'(m_cnt > 0));
      checkOutput("full", DW'(full), DW'(m_cnt == DEPTH));
      checkOutput("empty", DW'(empty), DW'(m_cnt == 0));
      checkOutput("overflow", DW'(overflow), DW'(m_drops > 0));
      checkOutput("dropped_count", DW'(dropped_count), DW'(m_drops));
`ifdef PIPELINE_RESULT_FIFO_CHECKSUM_EN
      checkOutput("checksum", checksum, m_xor);
`endif
      if (flush) begin
        m_cnt = 0; m_hold = 0; m_drops = 0; m_xor = '0;
        sb_q.delete();
      end else begin
        m_pop  = (m_cnt > 0) && out_ready;
        m_push = in_valid && !m_hold && ((m_cnt < DEPTH) || m_pop);
        if (m_push) begin
          sb_q.push_back(in_data);
          m_xor = m_xor ^ in_data;
        end
        if (in_valid && !m_push) begin
          m_hold  = 1;
          m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
        end
        m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    applyReset();

    // Basic ordering, then drain to empty.
    applyStimulus(1, 32'h11, 0, 0);
    applyStimulus(1, 32'h22, 0, 0);
    applyStimulus(1, 32'h33, 0, 0);
    applyStimulus(0, '0, 0, 0);
    repeat (3) applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 0, 0);

    // Fill, overflow, drain in OVF_HOLD, keep dropping while empty.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, DW'(32'h100 + i), 0, 0);
    applyStimulus(1, 32'hAA, 0, 0);
    repeat (DEPTH) applyStimulus(0, '0, 1, 0);
    applyStimulus(1, 32'hBB, 0, 0);
    applyStimulus(0, '0, 0, 0);

    // Flush with a simultaneous push; the word must not be stored.
    applyStimulus(1, 32'hCC, 1, 1);
    applyStimulus(1, 32'hDD, 0, 0);
    applyStimulus(0, '0, 1, 0);

    // Full with push+pop together across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, DW'(32'h200 + i), 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, DW'(32'h300 + i), 1, 0);
    applyStimulus(0, '0, 0, 0);
    repeat (DEPTH + 1) applyStimulus(0, '0, 1, 0);

    // Checksum pattern, then reset mid-stream.
    applyStimulus(0, '0, 0, 1);
    applyStimulus(1, 32'h0F, 0, 0);
    applyStimulus(1, 32'hF0, 0, 0);
    applyStimulus(1, 32'hFF, 0, 0);
    applyStimulus(0, '0, 0, 0);
    applyReset();
    applyStimulus(0, '0, 0, 0);

    // Saturate the drop counter.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, DW'(i), 0, 0);
    for (int i = 0; i < 65540; i++) applyStimulus(1, DW'(i), (i % 3) == 0, 0);
    applyStimulus(0, '0, 0, 0);
    applyStimulus(0, '0, 0, 1);

    // Randomized traffic with varying pressure, occasional flush and reset.
    for (int blk = 0; blk < 30; blk++) begin
      int pv = $urandom_range(20, 95);
      int pr = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 599) == 0) begin
          applyReset();
        end else begin
          applyStimulus($urandom_range(0, 99) < pv, $urandom,
                        $urandom_range(0, 99) < pr, $urandom_range(0, 249) == 0);
        end
      end
    end

    repeat (DEPTH + 2) applyStimulus(0, '0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
